// File: rtl/slow_clk_monitor.sv
// slow_clk_monitor
// Brings a slow divider-generated square wave into the clk_in domain,
// produces single-cycle edge strobes, measures the rise-to-rise period
// and reports lock / loss status for use as safe clock enables.
module slow_clk_monitor #(
    parameter int CNT_W      = 32,
    parameter int EXP_PERIOD = 100000000,
    parameter int TOL        = 1000000,
    parameter int TIMEOUT    = 150000000,
    parameter int LOCK_CNT   = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             slow_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOST    = 2'd2;

    localparam int GOOD_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]  TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  PER_MIN   = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [CNT_W-1:0]  PER_MAX   = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_CNT);

    logic              s1, s2, s3;
    logic [CNT_W-1:0]  cnt;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_inc;
    logic [1:0]        state;
    logic              rise_det;
    logic              fall_det;
    logic              at_timeout;
    logic              in_tol;

    assign rise_det   = s2 & ~s3;
    assign fall_det   = ~s2 & s3;
    assign at_timeout = (cnt == TIMEOUT_V);
    assign in_tol     = (cnt >= PER_MIN) && (cnt <= PER_MAX);
    assign good_inc   = (good_cnt == GOOD_MAX) ? GOOD_MAX : good_cnt + GOOD_W'(1);

    // Synchronizer chain and registered edge strobes.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the three-stage chain into a single wire.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            s1         <= slow_in;
            s2         <= s1;
            s3         <= s2;
            rise_pulse <= rise_det;
            fall_pulse <= fall_det;
        end
    end

    // Cycle counter: restarts at 1 on every rise, otherwise saturates at TIMEOUT.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt <= '0;
        end else if (rise_det) begin
            cnt <= CNT_W'(1);
        end else if (!at_timeout) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Lock/loss FSM with period capture; a rise always beats a timeout.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state        <= ST_IDLE;
            good_cnt     <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            lost         <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise_det) begin
                        state <= ST_MEASURE;
                    end else if (at_timeout) begin
                        state <= ST_LOST;
                        lost  <= 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (rise_det) begin
                        period       <= cnt;
                        period_valid <= 1'b1;
                        if (in_tol) begin
                            good_cnt <= good_inc;
                            if (good_inc == GOOD_MAX) begin
                                locked <= 1'b1;
                            end
                        end else begin
                            good_cnt <= '0;
                            locked   <= 1'b0;
                        end
                    end else if (at_timeout) begin
                        state    <= ST_LOST;
                        lost     <= 1'b1;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                    end
                end
                ST_LOST: begin
                    if (rise_det) begin
                        state <= ST_MEASURE;
                        lost  <= 1'b0;
                    end
                end
                // NOTE: the default arm recovers the unused encoding so the
                // state register can never stick in an undefined value.
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slow_clk_monitor.sv
// tb_slow_clk_monitor
// Self-checking bench for slow_clk_monitor with a short 20-cycle nominal
// period. Expected period/lock results are queued when a rise is driven and
// compared whenever the DUT strobes period_valid.
module tb_slow_clk_monitor;

    localparam int CNT_W      = 8;
    localparam int EXP_PERIOD = 20;
    localparam int TOL        = 2;
    localparam int TIMEOUT    = 40;
    localparam int LOCK_CNT   = 2;

    typedef struct {
        int p;
        bit l;
    } exp_t;

    logic             clk_in;
    logic             rst;
    logic             slow_in;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             lost;

    int   tests_run;
    int   tests_failed;
    exp_t sb[$];

    slow_clk_monitor #(
        .CNT_W      (CNT_W),
        .EXP_PERIOD (EXP_PERIOD),
        .TOL        (TOL),
        .TIMEOUT    (TIMEOUT),
        .LOCK_CNT   (LOCK_CNT)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .slow_in      (slow_in),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .lost         (lost)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(negedge clk_in);
    endtask

    // One slow_in cycle: rise, hold high, fall, hold low. The expectation
    // describes the period that ends at this rise.
    task automatic wave(input int hi, input int lo, input bit exp_v,
                        input int exp_p, input bit exp_l);
        exp_t e;
        if (exp_v) begin
            e.p = exp_p;
            e.l = exp_l;
            sb.push_back(e);
        end
        slow_in = 1'b1;
        repeat (hi) tick();
        slow_in = 1'b0;
        repeat (lo) tick();
    endtask

    // Scoreboard: every period_valid must match the oldest queued expectation.
    always @(negedge clk_in) begin
        exp_t e;
        if (period_valid === 1'b1) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_valid: period=%0d locked=%0b, required no period_valid",
                         period, locked);
            end else begin
                e = sb.pop_front();
                if (period !== CNT_W'(e.p) || locked !== e.l || rise_pulse !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL valid_result: period=%0d locked=%0b rise_pulse=%0b, required period=%0d locked=%0b rise_pulse=1",
                             period, locked, rise_pulse, e.p, e.l);
                end
            end
        end
        if (rise_pulse === 1'b1 || fall_pulse === 1'b1) begin
            tests_run++;
            if (rise_pulse === 1'b1 && fall_pulse === 1'b1) begin
                tests_failed++;
                $display("FAIL pulse_overlap: rise_pulse=1 fall_pulse=1, required at most one");
            end
        end
    end

    task automatic test_reset();
        rst     = 1'b1;
        slow_in = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({rise_pulse, fall_pulse, period_valid, locked, lost} !== 5'b0 || period !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: rp=%0b fp=%0b pv=%0b lk=%0b lost=%0b period=%0d, required all 0",
                     rise_pulse, fall_pulse, period_valid, locked, lost, period);
        end
        rst = 1'b0;
    endtask

    task automatic test_nominal_lock();
        wave(10, 10, 1'b0, 0, 1'b0);
        wave(10, 10, 1'b1, 20, 1'b0);
        wave(10, 10, 1'b1, 20, 1'b1);
        tests_run++;
        if (sb.size() != 0 || locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL nominal_lock: pending=%0d locked=%0b, required pending=0 locked=1",
                     sb.size(), locked);
        end
    endtask

    task automatic test_tolerance();
        wave(9, 9, 1'b1, 20, 1'b1);
        wave(11, 11, 1'b1, 18, 1'b1);
        wave(9, 8, 1'b1, 22, 1'b1);
        wave(10, 10, 1'b1, 17, 1'b0);
        wave(10, 10, 1'b1, 20, 1'b0);
        wave(12, 11, 1'b1, 20, 1'b1);
        wave(10, 10, 1'b1, 23, 1'b0);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL tolerance_drain: pending=%0d, required 0", sb.size());
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        wave(10, 10, 1'b1, 20, 1'b0);
        e.p = 20;
        e.l = 1'b1;
        sb.push_back(e);
        slow_in = 1'b1;
        repeat (10) tick();
        slow_in = 1'b0;
        repeat (32) tick();
        // cnt has just reached TIMEOUT; loss is reported one edge later.
        tests_run++;
        if (lost !== 1'b0 || locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_early: lost=%0b locked=%0b, required lost=0 locked=1", lost, locked);
        end
        tick();
        tests_run++;
        if (lost !== 1'b1 || locked !== 1'b0 || period_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_lost: lost=%0b locked=%0b pv=%0b, required lost=1 locked=0 pv=0",
                     lost, locked, period_valid);
        end
        repeat (5) tick();
        tests_run++;
        if (lost !== 1'b1 || period !== CNT_W'(20)) begin
            tests_failed++;
            $display("FAIL lost_hold: lost=%0b period=%0d, required lost=1 period=20", lost, period);
        end
        // Recovery rise: clears lost, no period report.
        slow_in = 1'b1;
        tick();
        tick();
        tests_run++;
        if (lost !== 1'b1) begin
            tests_failed++;
            $display("FAIL lost_recover_early: lost=%0b, required 1", lost);
        end
        tick();
        tests_run++;
        if (lost !== 1'b0 || rise_pulse !== 1'b1 || period_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL lost_recover: lost=%0b rp=%0b pv=%0b, required lost=0 rp=1 pv=0",
                     lost, rise_pulse, period_valid);
        end
        repeat (7) tick();
        slow_in = 1'b0;
        repeat (10) tick();
        wave(10, 10, 1'b1, 20, 1'b0);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL timeout_drain: pending=%0d, required 0", sb.size());
        end
    endtask

    task automatic test_latency();
        exp_t e;
        e.p = 20;
        e.l = 1'b1;
        sb.push_back(e);
        slow_in = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            tests_run++;
            if (rise_pulse !== (i == 3) || fall_pulse !== 1'b0) begin
                tests_failed++;
                $display("FAIL rise_latency: edge=%0d rp=%0b fp=%0b, required rp=%0b fp=0",
                         i, rise_pulse, fall_pulse, (i == 3));
            end
        end
        repeat (4) tick();
        slow_in = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            tests_run++;
            if (fall_pulse !== (i == 3) || rise_pulse !== 1'b0) begin
                tests_failed++;
                $display("FAIL fall_latency: edge=%0d fp=%0b rp=%0b, required fp=%0b rp=0",
                         i, fall_pulse, rise_pulse, (i == 3));
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        e.p = 20;
        e.l = 1'b1;
        sb.push_back(e);
        slow_in = 1'b1;
        repeat (5) tick();
        tests_run++;
        if (locked !== 1'b1 || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL pre_reset_lock: locked=%0b pending=%0d, required locked=1 pending=0",
                     locked, sb.size());
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if ({rise_pulse, fall_pulse, period_valid, locked, lost} !== 5'b0 || period !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: rp=%0b fp=%0b pv=%0b lk=%0b lost=%0b period=%0d, required all 0",
                     rise_pulse, fall_pulse, period_valid, locked, lost, period);
        end
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            tests_run++;
            if (rise_pulse !== (i == 3) || period_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL release_rise: edge=%0d rp=%0b pv=%0b, required rp=%0b pv=0",
                         i, rise_pulse, period_valid, (i == 3));
            end
        end
        tick();
        slow_in = 1'b0;
        repeat (16) tick();
        wave(10, 10, 1'b1, 20, 1'b0);
        wave(20, 20, 1'b1, 20, 1'b1);
    endtask

    task automatic test_rise_at_timeout();
        exp_t e;
        e.p = 40;
        e.l = 1'b0;
        sb.push_back(e);
        slow_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests_run++;
            if (lost !== 1'b0) begin
                tests_failed++;
                $display("FAIL coincident_lost: edge=%0d lost=%0b, required 0", i, lost);
            end
        end
        tests_run++;
        if (locked !== 1'b0 || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL coincident_result: locked=%0b pending=%0d, required locked=0 pending=0",
                     locked, sb.size());
        end
        repeat (6) tick();
        slow_in = 1'b0;
        repeat (10) tick();
        // Still measuring: the next good period must be reported.
        wave(10, 10, 1'b1, 20, 1'b0);
        tests_run++;
        if (sb.size() != 0 || lost !== 1'b0) begin
            tests_failed++;
            $display("FAIL coincident_state: pending=%0d lost=%0b, required pending=0 lost=0",
                     sb.size(), lost);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        slow_in      = 1'b0;
        test_reset();
        test_nominal_lock();
        test_tolerance();
        test_timeout();
        test_latency();
        test_reset_mid();
        test_rise_at_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/slow_clk_monitor.md
Name: slow_clk_monitor

Overview:
Receive-side companion to the team's clock dividers. Takes a slow, divider-generated square wave (nominally 1 Hz) back into the fast clk_in domain and synchronizes it. Produces single-cycle edge strobes, measures the period in clk_in cycles, and reports lock/loss status. Game logic uses the strobes as safe enables instead of clocking flops from a divided clock.

Parameters:
CNT_W, 32, width of the cycle counter and period output; TIMEOUT must be < 2^CNT_W.
EXP_PERIOD, 100000000, expected full period of slow_in in clk_in cycles.
TOL, 1000000, allowed absolute deviation from EXP_PERIOD, inclusive.
TIMEOUT, 150000000, cycles without a rising edge before loss is declared.
LOCK_CNT, 2, consecutive in-tolerance periods required to assert locked (>=1).

Ports:
clk_in  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
slow_in  input  1  slow square wave, asynchronous to clk_in.
rise_pulse  output  1  one-cycle strobe per synchronized rising edge.
fall_pulse  output  1  one-cycle strobe per synchronized falling edge.
period  output  CNT_W  last measured rise-to-rise period in clk_in cycles.
period_valid  output  1  one-cycle strobe when period updates.
locked  output  1  LOCK_CNT consecutive good periods seen, no fault since.
lost  output  1  no rising edge within TIMEOUT cycles.

Behaviour:
- Reset: one clk_in edge with rst=1 clears all outputs, sync flops s1/s2/s3, cnt, good_cnt; state=IDLE. Applies mid-operation, and rst overrides all other events.
- Sync: s1<=slow_in, s2<=s1, s3<=s2. rise_det = s2 & ~s3, fall_det = ~s2 & s3.
- Strobes are registered, so slow_in change to strobe = 3 clk_in edges. Each is high exactly one cycle per edge.
- If slow_in is high at reset release, rise_pulse fires 3 cycles later. That rise counts as the IDLE first edge.
- cnt rule, all states: on rise_det, cnt<=1. Otherwise cnt<=cnt+1, held (saturated) at TIMEOUT.
- FSM states: IDLE, MEASURE, LOST.
- IDLE: rise_det -> MEASURE, with no period_valid. cnt==TIMEOUT and no rise_det -> LOST.
- MEASURE, on rise_det:
  - period<=cnt and period_valid<=1.
  - Good period is EXP_PERIOD-TOL <= cnt <= EXP_PERIOD+TOL: good_cnt increments, saturating at LOCK_CNT. locked<=1 when the incremented value reaches LOCK_CNT.
  - Bad period: good_cnt<=0 and locked<=0, in the same cycle as period_valid.
  - Stay in MEASURE.
- MEASURE, cnt==TIMEOUT and no rise_det: -> LOST, lost<=1, locked<=0, good_cnt<=0, no period_valid.
- LOST: period holds its last value. rise_det -> MEASURE, lost<=0, cnt<=1, no period_valid on that edge.
- Simultaneous rise_det and cnt==TIMEOUT: the rise wins. In MEASURE, period<=TIMEOUT is captured and judged against tolerance normally.
- Period definition: clk_in cycles between consecutive synchronized rises. A divider toggling every N cycles gives period=2N.
- The high/low duty cycle is not checked. fall_pulse is informational only.

Test Plan:
(Bench params: EXP_PERIOD=20, TOL=2, TIMEOUT=40, LOCK_CNT=2, CNT_W=8.)
1. Nominal lock: slow_in toggles every 10 cycles from reset.
   - 1st rise: no period_valid.
   - 2nd rise: period_valid with period=20, locked=0.
   - 3rd rise: period=20 and locked=1 in the same cycle.
2. Tolerance bounds: from locked, periods 18 then 22 keep locked=1. A period of 17 drops locked the same cycle as period_valid (period=17). A period of 23 behaves the same as 17.
3. Timeout: after a rise, hold slow_in low. lost=1 and locked=0 the cycle after cnt reaches 40, with no period_valid. The next rise clears lost without period_valid, and the following 20-cycle period gives period=20.
4. Latency: a single 0->1 on slow_in gives rise_pulse high exactly one cycle, 3 clk_in edges later. A later 1->0 gives fall_pulse the same way. Pulses never overlap.
5. Reset mid-operation: assert rst for 1 cycle while locked=1 and slow_in=1.
   - Next cycle: all outputs 0.
   - rise_pulse 3 cycles after release, with no period_valid.
   - Lock requires 2 fresh good periods.
6. Rise coincident with timeout: drive a rise so rise_det lands on the cycle cnt==40. Expect period_valid with period=40, lost=0, locked=0, state MEASURE.
